// File: rtl/mem_arbiter.sv
// Purpose: two-port round-robin arbiter in front of a single-port synchronous data memory.
// Latency: write ack 2 cycles, read data 3 cycles after the accepting edge.
// Backpressure: one transaction in flight; req*_ready is asserted only in IDLE, only to the winner.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   req{0,1}_valid/we/addr/wdata/ready   request handshake per port
//   rsp{0,1}_valid/rdata     one-cycle response pulse, read data held until next read
//   mem_addr/mem_we/mem_wdata/mem_rdata  registered memory interface, read data one cycle after addr
//   busy, grant_id           transaction in progress / owning port
module mem_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  last_gnt_q, last_gnt_d;
    logic                  grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DATA_WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;
    logic                  winner;

    always_comb begin
        // On a tie the port that did not win last time goes first; a lone
        // requester always wins.
        winner = (req0_valid && req1_valid) ? ~last_gnt_q : req1_valid;

        // Reset outranks any request presented in the same cycle.
        req0_ready = !rst && (state_q == IDLE) && req0_valid && !winner;
        req1_ready = !rst && (state_q == IDLE) && req1_valid && winner;

        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        grant_d      = grant_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;        // write strobe lives for the ACCESS cycle only
        mem_wdata_d  = mem_wdata_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_d     = winner;
                    last_gnt_d  = winner;
                    mem_addr_d  = winner ? req1_addr  : req0_addr;
                    mem_we_d    = winner ? req1_we    : req0_we;
                    mem_wdata_d = winner ? req1_wdata : req0_wdata;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                // mem_we_q still holds the latched request type here.
                if (mem_we_q) begin
                    rsp0_valid_d = !grant_q;
                    rsp1_valid_d = grant_q;
                    state_d      = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (grant_q) begin
                    rsp1_rdata_d = mem_rdata;
                end else begin
                    rsp0_rdata_d = mem_rdata;
                end
                rsp0_valid_d = !grant_q;
                rsp1_valid_d = grant_q;
                state_d      = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_gnt_q   <= 1'b1;
            grant_q      <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            grant_q      <= grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;
    assign busy       = (state_q != IDLE);
    assign grant_id   = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter with a behavioural memory and a transaction-level model.
// Latency: model predicts accept cycles, response cycles (+2 write, +3 read) and read data.
// Backpressure: requesters hold valid and fields until ready, as a real requester would.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_we, req0_ready, rsp0_valid;
    logic [5:0]  req0_addr;
    logic [15:0] req0_wdata, rsp0_rdata;
    logic        req1_valid, req1_we, req1_ready, rsp1_valid;
    logic [5:0]  req1_addr;
    logic [15:0] req1_wdata, rsp1_rdata;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata, mem_rdata;
    logic        busy, grant_id;

    // preload path into the backing memory, used only while the DUT is idle
    logic        pl_we;
    logic [5:0]  pl_addr;
    logic [15:0] pl_dat;

    logic [15:0] tb_mem  [64];   // the memory the DUT talks to
    logic [15:0] ref_mem [64];   // the model's idea of memory contents

    int vectors;
    int miscompares;

    mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            tb_mem[mem_addr] <= mem_wdata;
        end else if (pl_we) begin
            tb_mem[pl_addr] <= pl_dat;
        end
        mem_rdata <= tb_mem[mem_addr];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic preload(input int a, input logic [15:0] d);
        pl_we   = 1'b1;
        pl_addr = 6'(a);
        pl_dat  = d;
        ref_mem[a] = d;
        next_cycle();
        pl_we = 1'b0;
    endtask

    task automatic test_reset();
        // requests presented while reset is held must not be accepted
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready_prio: ready=%b expected 00", {req0_ready, req1_ready});
        end
        vectors++;
        if ({busy, grant_id, mem_addr, mem_we, mem_wdata, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b gid=%b addr=%h we=%b wd=%h rv=%b%b rd0=%h rd1=%h expected all 0",
                     busy, grant_id, mem_addr, mem_we, mem_wdata, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata);
        end
        next_cycle();
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_read();
        preload(8, 16'h1234);
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'h08; req0_wdata = 16'h0;
        @(negedge clk);
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL read_ready: ready=%b expected 10", {req0_ready, req1_ready});
        end
        next_cycle();
        req0_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_addr, mem_we, busy, grant_id} !== {6'h08, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL read_access: addr=%h we=%b busy=%b gid=%b expected 08 0 1 0", mem_addr, mem_we, busy, grant_id);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL read_early_rsp: rsp=%b expected 00", {rsp0_valid, rsp1_valid});
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({rsp0_valid, rsp1_valid, rsp0_rdata} !== {2'b10, 16'h1234}) begin
            miscompares++;
            $display("FAIL read_rsp: rsp=%b rdata=%h expected 10 1234", {rsp0_valid, rsp1_valid}, rsp0_rdata);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({rsp0_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL read_done: rsp0=%b busy=%b expected 0 0", rsp0_valid, busy);
        end
        next_cycle();
    endtask

    task automatic test_write();
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 6'h3F; req1_wdata = 16'hBEEF;
        @(negedge clk);
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL write_ready: ready=%b expected 01", {req0_ready, req1_ready});
        end
        ref_mem[63] = 16'hBEEF;
        next_cycle();
        req1_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_we, mem_addr, mem_wdata, grant_id} !== {1'b1, 6'h3F, 16'hBEEF, 1'b1}) begin
            miscompares++;
            $display("FAIL write_access: we=%b addr=%h wd=%h gid=%b expected 1 3f beef 1", mem_we, mem_addr, mem_wdata, grant_id);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({mem_we, rsp1_valid, rsp0_valid} !== 3'b010) begin
            miscompares++;
            $display("FAIL write_ack: we=%b rsp1=%b rsp0=%b expected 0 1 0", mem_we, rsp1_valid, rsp0_valid);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({rsp1_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL write_done: rsp1=%b busy=%b expected 0 0", rsp1_valid, busy);
        end
        next_cycle();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'h3F;
        next_cycle();
        req0_valid = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({rsp0_valid, rsp0_rdata} !== {1'b1, ref_mem[63]}) begin
            miscompares++;
            $display("FAIL write_readback: rsp0=%b rdata=%h expected 1 %h", rsp0_valid, rsp0_rdata, ref_mem[63]);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        int n0, n1, k, due;
        logic dport;
        logic [15:0] ddat;
        logic [1:0] exp_rdy;
        logic e_acc;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            preload(i, 16'($urandom_range(0, 65535)));
            preload(32 + i, 16'($urandom_range(0, 65535)));
        end
        n0 = 0; n1 = 0; k = 0; due = -1; dport = 1'b0; ddat = '0;
        for (int c = 0; c < 34; c++) begin
            req0_valid = (n0 < 4); req0_we = 1'b0; req0_addr = 6'(n0);
            req1_valid = (n1 < 4); req1_we = 1'b0; req1_addr = 6'(32 + n1);
            @(negedge clk);
            // reads are accepted every 4 cycles; grants alternate starting at port 0
            e_acc   = (c % 4 == 0) && (k < 8);
            exp_rdy = e_acc ? ((k % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
            vectors++;
            if ({req0_ready, req1_ready} !== exp_rdy) begin
                miscompares++;
                $display("FAIL contention_grant c=%0d: ready=%b expected %b", c, {req0_ready, req1_ready}, exp_rdy);
            end
            vectors++;
            if ({rsp0_valid, rsp1_valid} !== {due == c && !dport, due == c && dport}) begin
                miscompares++;
                $display("FAIL contention_rsp c=%0d: rsp=%b expected %b", c, {rsp0_valid, rsp1_valid},
                         {due == c && !dport, due == c && dport});
            end
            if (due == c) begin
                vectors++;
                if ((dport ? rsp1_rdata : rsp0_rdata) !== ddat) begin
                    miscompares++;
                    $display("FAIL contention_data c=%0d port=%0d: rdata=%h expected %h", c, dport,
                             dport ? rsp1_rdata : rsp0_rdata, ddat);
                end
            end
            if (e_acc) begin
                dport = (k % 2 == 1);
                if (!dport) begin
                    ddat = ref_mem[n0];
                    n0++;
                end else begin
                    ddat = ref_mem[32 + n1];
                    n1++;
                end
                due = c + 3;
                k++;
            end
            next_cycle();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd5;
        @(negedge clk);
        vectors++;
        if (req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rstwait_accept: ready0=%b expected 1", req0_ready);
        end
        next_cycle();           // ACCESS
        req0_valid = 1'b0;
        next_cycle();           // WAIT
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, grant_id, mem_addr, mem_we, mem_wdata, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata} !== '0) begin
            miscompares++;
            $display("FAIL rstwait_outputs: busy=%b gid=%b addr=%h we=%b wd=%h rv=%b%b rd0=%h rd1=%h expected all 0",
                     busy, grant_id, mem_addr, mem_we, mem_wdata, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata);
        end
        next_cycle();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 6'd32;
        @(negedge clk);
        vectors++;
        if ({rsp0_valid, req0_ready, req1_ready} !== 3'b010) begin
            miscompares++;
            $display("FAIL rstwait_tie: rsp0=%b ready=%b expected 0 10", rsp0_valid, {req0_ready, req1_ready});
        end
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (4) next_cycle();
    endtask

    task automatic test_back_to_back();
        int k;
        for (int i = 10; i < 13; i++) preload(i, 16'($urandom_range(0, 65535)));
        k = 0;
        for (int c = 0; c < 13; c++) begin
            req0_valid = (c < 12); req0_we = 1'b0; req0_addr = 6'(10 + k);
            req1_valid = 1'b0;
            @(negedge clk);
            vectors++;
            if ({req0_ready, req1_ready, rsp1_valid, rsp0_valid} !== {c % 4 == 0 && c < 12, 2'b00, c % 4 == 3}) begin
                miscompares++;
                $display("FAIL b2b c=%0d: ready0=%b ready1=%b rsp1=%b rsp0=%b expected %b 0 0 %b", c,
                         req0_ready, req1_ready, rsp1_valid, rsp0_valid, c % 4 == 0 && c < 12, c % 4 == 3);
            end
            if (c % 4 == 3) begin
                vectors++;
                if (rsp0_rdata !== ref_mem[10 + c / 4]) begin
                    miscompares++;
                    $display("FAIL b2b_data c=%0d: rdata=%h expected %h", c, rsp0_rdata, ref_mem[10 + c / 4]);
                end
            end
            if (c % 4 == 0) k++;
            next_cycle();
        end
    endtask

    task automatic test_reset_in_access();
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 6'h10; req1_wdata = 16'h5555;
        @(negedge clk);
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL rstacc_accept: ready=%b expected 01", {req0_ready, req1_ready});
        end
        ref_mem[16] = 16'h5555;
        next_cycle();           // ACCESS, reset arrives with the write on the bus
        req1_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 6'h10, 16'h5555}) begin
            miscompares++;
            $display("FAIL rstacc_bus: we=%b addr=%h wd=%h expected 1 10 5555", mem_we, mem_addr, mem_wdata);
        end
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({rsp1_valid, rsp0_valid, busy, mem_we} !== 4'b0000) begin
                miscompares++;
                $display("FAIL rstacc_norsp c=%0d: rsp1=%b rsp0=%b busy=%b we=%b expected 0 0 0 0",
                         c, rsp1_valid, rsp0_valid, busy, mem_we);
            end
            next_cycle();
        end
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'h10;
        next_cycle();
        req0_valid = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({rsp0_valid, rsp0_rdata} !== {1'b1, 16'h5555}) begin
            miscompares++;
            $display("FAIL rstacc_readback: rsp0=%b rdata=%h expected 1 5555", rsp0_valid, rsp0_rdata);
        end
        next_cycle();
    endtask

    task automatic test_random(input int ncyc);
        int free_at, due, am_cyc;
        logic lg, w, dport, drd, acc0, acc1, acc, am_we;
        logic [5:0] am_addr, a;
        logic [15:0] ddat, last0, last1, am_dat;
        logic [1:0] exp_rdy;
        apply_reset();
        for (int i = 0; i < 8; i++) preload(i, 16'($urandom_range(0, 65535)));
        free_at = 0; due = -1; am_cyc = -1; lg = 1'b1;
        dport = 1'b0; drd = 1'b0; ddat = '0; last0 = '0; last1 = '0;
        acc0 = 1'b0; acc1 = 1'b0; am_we = 1'b0; am_addr = '0; am_dat = '0;
        for (int c = 0; c < ncyc; c++) begin
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_we    = 1'($urandom_range(0, 1));
                req0_addr  = 6'($urandom_range(0, 7));
                req0_wdata = 16'($urandom_range(0, 65535));
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_we    = 1'($urandom_range(0, 1));
                req1_addr  = 6'($urandom_range(0, 7));
                req1_wdata = 16'($urandom_range(0, 65535));
            end
            @(negedge clk);
            acc = (c >= free_at) && (req0_valid || req1_valid);
            w = (req0_valid && req1_valid) ? !lg : req1_valid;
            exp_rdy = acc ? (w ? 2'b01 : 2'b10) : 2'b00;
            vectors++;
            if ({req0_ready, req1_ready} !== exp_rdy) begin
                miscompares++;
                $display("FAIL rand_ready c=%0d: ready=%b expected %b", c, {req0_ready, req1_ready}, exp_rdy);
            end
            vectors++;
            if (busy !== (c < free_at)) begin
                miscompares++;
                $display("FAIL rand_busy c=%0d: busy=%b expected %b", c, busy, c < free_at);
            end
            vectors++;
            if ({rsp0_valid, rsp1_valid} !== {due == c && !dport, due == c && dport}) begin
                miscompares++;
                $display("FAIL rand_rsp c=%0d: rsp=%b expected %b", c, {rsp0_valid, rsp1_valid},
                         {due == c && !dport, due == c && dport});
            end
            if (due == c && drd) begin
                if (dport) last1 = ddat;
                else       last0 = ddat;
            end
            vectors++;
            if ({rsp0_rdata, rsp1_rdata} !== {last0, last1}) begin
                miscompares++;
                $display("FAIL rand_rdata c=%0d: rd0=%h rd1=%h expected %h %h", c, rsp0_rdata, rsp1_rdata, last0, last1);
            end
            vectors++;
            if (mem_we !== (am_cyc == c && am_we)) begin
                miscompares++;
                $display("FAIL rand_we c=%0d: mem_we=%b expected %b", c, mem_we, am_cyc == c && am_we);
            end
            if (am_cyc == c) begin
                vectors++;
                if (mem_addr !== am_addr || (am_we && mem_wdata !== am_dat)) begin
                    miscompares++;
                    $display("FAIL rand_bus c=%0d: addr=%h wd=%h expected %h %h", c, mem_addr, mem_wdata, am_addr, am_dat);
                end
            end
            acc0 = acc && !w;
            acc1 = acc && w;
            if (acc) begin
                lg      = w;
                a       = w ? req1_addr : req0_addr;
                am_we   = w ? req1_we : req0_we;
                am_dat  = w ? req1_wdata : req0_wdata;
                am_addr = a;
                am_cyc  = c + 1;
                dport   = w;
                drd     = !am_we;
                if (am_we) begin
                    ref_mem[a] = am_dat;
                    due        = c + 2;
                    free_at    = c + 3;
                end else begin
                    ddat    = ref_mem[a];
                    due     = c + 3;
                    free_at = c + 4;
                end
            end
            next_cycle();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        pl_we = 1'b0; pl_addr = '0; pl_dat = '0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
        next_cycle();
        test_reset();
        test_read();
        test_write();
        test_contention();
        test_reset_in_wait();
        test_back_to_back();
        test_reset_in_access();
        test_random(400);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
